// File: rtl/gate_truth_table_checker_pkg.sv
// Shared types and helpers for the gate truth-table checker.
package gate_chk_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   localparam int N_IN_DEF = 2;
   localparam int N_VEC    = 2**N_IN_DEF;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// Settle-window counter: counts up from 0 while clr is low, holding at SETTLE-1.
module settle_timer #(
   parameter int SETTLE = 1,
   parameter int W      = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tc
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      tc    = (cnt_q == W'(SETTLE - 1));
      cnt_d = cnt_q;
      if (clr)      cnt_d = '0;
      else if (!tc) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Walks every input vector of a small gate, samples its output after a settle
// window and scores it against the EXPECTED truth table.
module gate_truth_table_checker
   import gate_chk_pkg::*;
#(
   parameter int                 N_IN     = 2,
   parameter logic [2**N_IN-1:0] EXPECTED = 4'b1000,
   parameter int                 SETTLE   = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic [N_IN-1:0]              gate_in,
   input  logic                         gate_out,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [$clog2(2**N_IN+1)-1:0] err_count,
   output logic [2**N_IN-1:0]           fail_vec
);

   localparam int               NV      = 2**N_IN;
   localparam int               EW      = $clog2(NV + 1);
   localparam int               TW      = cnt_w(SETTLE);
   localparam logic [N_IN:0]    LAST    = (N_IN+1)'(NV - 1);
   localparam logic [EW-1:0]    ERR_MAX = EW'(NV);

   state_t            state_q, state_d;
   logic [N_IN:0]     idx_q, idx_d;
   logic [N_IN-1:0]   gate_in_q, gate_in_d;
   logic [EW-1:0]     err_q, err_d;
   logic [NV-1:0]     fail_q, fail_d;
   logic              pass_q, pass_d;
   logic              tmr_clr, tmr_tc, mism;

   settle_timer #(.SETTLE(SETTLE), .W(TW)) u_settle (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .tc    (tmr_tc)
   );

   // Case inequality so an X/Z from the gate is scored as a mismatch.
   assign mism = (gate_out !== EXPECTED[idx_q[N_IN-1:0]]);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      gate_in_d = gate_in_q;
      err_d     = err_q;
      fail_d    = fail_q;
      pass_d    = pass_q;
      tmr_clr   = 1'b1;
      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d     = '0;
               gate_in_d = '0;
               err_d     = '0;
               fail_d    = '0;
               pass_d    = 1'b0;
               state_d   = DRIVE;
            end
         end
         DRIVE: begin
            tmr_clr = 1'b0;
            if (tmr_tc) state_d = SAMPLE;
         end
         SAMPLE: begin
            if (mism) begin
               fail_d[idx_q[N_IN-1:0]] = 1'b1;
               if (err_q != ERR_MAX) err_d = err_q + EW'(1);
            end
            if (idx_q == LAST) begin
               pass_d  = (err_d == '0);
               state_d = DONE;
            end else begin
               idx_d     = idx_q + (N_IN+1)'(1);
               gate_in_d = idx_d[N_IN-1:0];
               state_d   = DRIVE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         gate_in_q <= '0;
         err_q     <= '0;
         fail_q    <= '0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         gate_in_q <= gate_in_d;
         err_q     <= err_d;
         fail_q    <= fail_d;
         pass_q    <= pass_d;
      end
   end

   assign gate_in   = gate_in_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Scoreboard bench for gate_truth_table_checker: default 2-input AND build plus a 3-input XOR build.
module tb_gate_truth_table_checker;

   typedef struct packed {
      logic       pass;
      logic [2:0] err;
      logic [3:0] fv;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start, go, busy, done, pass;
   logic [1:0] gi;
   logic [2:0] errc;
   logic [3:0] failv;

   logic       start3, go3, busy3, done3, pass3;
   logic [2:0] gi3;
   logic [3:0] errc3;
   logic [7:0] failv3;

   int   mode;
   logic xv;
   int   n_vec, n_mis;
   int   exp_gi[$];
   int   obs_gi[$];
   res_t exp_res[$];
   int   done_at;

   gate_truth_table_checker u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .gate_in(gi), .gate_out(go),
      .busy(busy), .done(done), .pass(pass), .err_count(errc), .fail_vec(failv)
   );

   gate_truth_table_checker #(.N_IN(3), .EXPECTED(8'b10010110), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .gate_in(gi3), .gate_out(go3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(errc3), .fail_vec(failv3)
   );

   // Gate under test models: 0 AND, 1 OR, 2 AND with X on vector 2, 3 NAND.
   always_comb begin
      case (mode)
         1:       go = |gi;
         2:       go = (gi == 2'd2) ? xv : &gi;
         3:       go = ~&gi;
         default: go = &gi;
      endcase
   end
   assign go3 = ^gi3;

   task automatic push_seq(input int s, input int nv);
      for (int c = 0; c < nv * (s + 1); c++) exp_gi.push_back(c / (s + 1));
   endtask

   task automatic launch(input bit hold);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = hold;
   endtask

   // Records gate_in each busy cycle until done; p1/p2 are edges (k+p) that see a stray start.
   task automatic watch(input int p1, input int p2, input bit hold);
      obs_gi.delete();
      done_at = -1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done) begin
            done_at = c;
            return;
         end
         if (busy) obs_gi.push_back(int'(gi));
         start = hold || (c + 1 == p1) || (c + 1 == p2);
      end
   endtask

   task automatic test_reset();
      #12;
      n_vec++;
      if ({gi, busy, done, pass, errc, failv} !== 12'd0) begin
         n_mis++;
         $display("FAIL reset_state: got gi=%0d busy=%b done=%b pass=%b err=%0d fv=%b want all zero",
                  gi, busy, done, pass, errc, failv);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_and_seq(input int p1, input int p2, input string nm);
      res_t got;
      mode = 0;
      push_seq(1, 4);
      exp_res.push_back('{pass: 1'b1, err: 3'd0, fv: 4'b0000});
      launch(1'b0);
      watch(p1, p2, 1'b0);
      while (exp_gi.size() > 0) begin
         int e, o;
         e = exp_gi.pop_front();
         o = (obs_gi.size() > 0) ? obs_gi.pop_front() : -1;
         n_vec++;
         if (o !== e) begin
            n_mis++;
            $display("FAIL %s gate_in: got %0d want %0d", nm, o, e);
         end
      end
      n_vec++;
      if (done_at !== 8) begin
         n_mis++;
         $display("FAIL %s done_time: got %0d want 8", nm, done_at);
      end
      got = {pass, errc, failv};
      n_vec++;
      if (got !== exp_res[0]) begin
         n_mis++;
         $display("FAIL %s result: got %b want %b", nm, got, exp_res[0]);
      end
      void'(exp_res.pop_front());
   endtask

   task automatic test_and();
      test_and_seq(-1, -1, "and");
   endtask

   task automatic test_mid_start();
      test_and_seq(3, 5, "mid_start");
   endtask

   task automatic test_or();
      res_t got;
      mode = 1;
      exp_res.push_back('{pass: 1'b0, err: 3'd2, fv: 4'b0110});
      launch(1'b0);
      watch(-1, -1, 1'b0);
      got = {pass, errc, failv};
      n_vec++;
      if (done_at !== 8 || got !== exp_res[0]) begin
         n_mis++;
         $display("FAIL or_gate: got done_at=%0d res=%b want 8 %b", done_at, got, exp_res[0]);
      end
      void'(exp_res.pop_front());
   endtask

   task automatic test_all_fail();
      res_t got;
      mode = 3;
      exp_res.push_back('{pass: 1'b0, err: 3'd4, fv: 4'b1111});
      launch(1'b0);
      watch(-1, -1, 1'b0);
      got = {pass, errc, failv};
      n_vec++;
      if (got !== exp_res[0]) begin
         n_mis++;
         $display("FAIL all_fail: got %b want %b", got, exp_res[0]);
      end
      void'(exp_res.pop_front());
   endtask

   task automatic test_reset_mid();
      int ndone;
      mode = 1;
      launch(1'b0);
      repeat (4) @(posedge clk);
      #1;
      n_vec++;
      if (gi !== 2'd2 || errc !== 3'd1) begin
         n_mis++;
         $display("FAIL pre_abort: got gi=%0d err=%0d want gi=2 err=1", gi, errc);
      end
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({gi, busy, done, errc, failv} !== 11'd0) begin
         n_mis++;
         $display("FAIL abort_state: got gi=%0d busy=%b done=%b err=%0d fv=%b want zero",
                  gi, busy, done, errc, failv);
      end
      @(negedge clk) rst_n = 1'b1;
      ndone = 0;
      repeat (20) @(negedge clk) if (done) ndone++;
      n_vec++;
      if (ndone !== 0) begin
         n_mis++;
         $display("FAIL abort_no_done: got %0d done pulses want 0", ndone);
      end
      mode = 0;
      launch(1'b0);
      watch(-1, -1, 1'b0);
      n_vec++;
      if (done_at !== 8 || pass !== 1'b1) begin
         n_mis++;
         $display("FAIL after_abort: got done_at=%0d pass=%b want 8 1", done_at, pass);
      end
   endtask

   task automatic test_back_to_back();
      mode = 0;
      launch(1'b1);
      watch(-1, -1, 1'b1);
      n_vec++;
      if (done_at !== 8) begin
         n_mis++;
         $display("FAIL b2b_first_done: got %0d want 8", done_at);
      end
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0) begin
         n_mis++;
         $display("FAIL b2b_idle_gap: got busy=%b want 0", busy);
      end
      @(negedge clk);
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || gi !== 2'd0) begin
         n_mis++;
         $display("FAIL b2b_restart: got busy=%b gi=%0d want 1 0", busy, gi);
      end
      watch(-1, -1, 1'b0);
      n_vec++;
      if (done_at !== 7 || pass !== 1'b1) begin
         n_mis++;
         $display("FAIL b2b_second: got done_at=%0d pass=%b want 7 1", done_at, pass);
      end
   endtask

   task automatic test_settle3();
      int d3;
      d3 = -1;
      push_seq(3, 8);
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done3) begin
            d3 = c;
            break;
         end
         if (busy3 && exp_gi.size() > 0) begin
            int e;
            e = exp_gi.pop_front();
            n_vec++;
            if (int'(gi3) !== e) begin
               n_mis++;
               $display("FAIL settle3 gate_in c=%0d: got %0d want %0d", c, gi3, e);
            end
         end
      end
      n_vec++;
      if (d3 !== 32 || exp_gi.size() != 0) begin
         n_mis++;
         $display("FAIL settle3_done: got %0d (left %0d) want 32 (left 0)", d3, exp_gi.size());
      end
      exp_gi.delete();
      n_vec++;
      if (pass3 !== 1'b1 || errc3 !== 4'd0 || failv3 !== 8'd0) begin
         n_mis++;
         $display("FAIL settle3_result: got pass=%b err=%0d fv=%b want 1 0 0", pass3, errc3, failv3);
      end
   endtask

   task automatic test_x();
      res_t got;
      logic bad;
      bad = (xv !== 1'b0);
      mode = 2;
      exp_res.push_back('{pass: !bad, err: bad ? 3'd1 : 3'd0, fv: bad ? 4'b0100 : 4'b0000});
      launch(1'b0);
      watch(-1, -1, 1'b0);
      got = {pass, errc, failv};
      n_vec++;
      if (got !== exp_res[0]) begin
         n_mis++;
         $display("FAIL x_vector: got %b want %b", got, exp_res[0]);
      end
      void'(exp_res.pop_front());
   endtask

   initial begin
      start  = 1'b0;
      start3 = 1'b0;
      mode   = 0;
      xv     = 1'bx;
      n_vec  = 0;
      n_mis  = 0;
      test_reset();
      test_and();
      test_or();
      test_all_fail();
      test_mid_start();
      test_reset_mid();
      test_back_to_back();
      test_settle3();
      test_x();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
